// File: rtl/riscv_booth4_multiplier.sv
// Purpose : sequential radix-4 (modified Booth) multiplier for RV32M/RV64M MUL, MULH, MULHSU, MULHU, MULW.
// Latency : accept edge t -> valid in cycle t+N+1 (N = XLEN/2+1, 17 for MULW); zero operand -> t+1.
// Backpressure: none; start is sampled only in IDLE and dropped otherwise, busy stalls the pipe, kill aborts.
//
// Ports:
//   i_riscv_mul_clk / i_riscv_mul_rst   clock (rising edge) / asynchronous active-high reset
//   i_riscv_mul_start, i_riscv_mul_kill request / pipeline flush (kill wins over start)
//   i_riscv_mul_op                      000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 MULW (RV64 only)
//   i_riscv_mul_rs1data / rs2data       multiplicand / multiplier
//   o_riscv_mul_product                 result, held until the next accepted operation completes
//   o_riscv_mul_valid / o_riscv_mul_busy one-cycle result strobe / operation in flight
module riscv_booth4_multiplier #(
    parameter int XLEN = 64
) (
    input  logic            i_riscv_mul_clk,
    input  logic            i_riscv_mul_rst,
    input  logic            i_riscv_mul_start,
    input  logic            i_riscv_mul_kill,
    input  logic [2:0]      i_riscv_mul_op,
    input  logic [XLEN-1:0] i_riscv_mul_rs1data,
    input  logic [XLEN-1:0] i_riscv_mul_rs2data,
    output logic [XLEN-1:0] o_riscv_mul_product,
    output logic            o_riscv_mul_valid,
    output logic            o_riscv_mul_busy
);

    localparam int W    = XLEN + 2;        // two guard bits let MULHU/MULHSU operands stay positive
    localparam int N    = W / 2;
    localparam int NW   = 17;              // MULW works on a 34-bit extension
    localparam int AW   = 2 * W + 1;
    localparam int CW   = $clog2(N);
    localparam int WLSB = W - 2 * NW;      // product LSB position after only NW steps

    localparam logic [CW-1:0] LAST_FULL = CW'(N - 1);
    localparam logic [CW-1:0] LAST_W    = CW'(NW - 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_MULW   = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_acc;
    logic            r_yprev;
    logic [W-1:0]    r_x;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_product;

    logic [2:0]      w_op;
    logic [W-1:0]    w_x_ext, w_y_ext;
    logic            w_zero, w_accept, w_last;
    logic [W:0]      w_x1, w_x2, w_addend, w_sum;
    logic [AW-1:0]   w_acc_nxt;
    logic [2:0]      w_digit;
    logic [31:0]     w_w32;
    logic [XLEN-1:0] w_result;
    logic            w_unused_acc;

    // Reserved encodings, and MULW on RV32, behave as plain MUL.
    always_comb begin
        w_op = i_riscv_mul_op;
        if (i_riscv_mul_op > OP_MULW || (i_riscv_mul_op == OP_MULW && XLEN != 64))
            w_op = OP_MUL;
    end

    always_comb begin
        w_x_ext = {{2{i_riscv_mul_rs1data[XLEN-1]}}, i_riscv_mul_rs1data};
        w_y_ext = {{2{i_riscv_mul_rs2data[XLEN-1]}}, i_riscv_mul_rs2data};
        case (w_op)
            OP_MULHSU: w_y_ext = {2'b00, i_riscv_mul_rs2data};
            OP_MULHU: begin
                w_x_ext = {2'b00, i_riscv_mul_rs1data};
                w_y_ext = {2'b00, i_riscv_mul_rs2data};
            end
            OP_MULW: begin
                w_x_ext = W'($signed(i_riscv_mul_rs1data[31:0]));
                w_y_ext = W'($signed(i_riscv_mul_rs2data[31:0]));
            end
            default: ;
        endcase
    end

    assign w_zero   = (w_x_ext == '0) || (w_y_ext == '0);
    assign w_accept = (r_state == S_IDLE) && i_riscv_mul_start && !i_riscv_mul_kill;
    assign w_last   = (r_count == ((r_op == OP_MULW) ? LAST_W : LAST_FULL));

    // Booth digit from the two lowest unconsumed multiplier bits plus the last bit shifted out.
    assign w_digit = {r_acc[1], r_acc[0], r_yprev};
    assign w_x1    = {r_x[W-1], r_x};
    assign w_x2    = {r_x, 1'b0};

    always_comb begin
        case (w_digit)
            3'b001, 3'b010: w_addend = w_x1;
            3'b011:         w_addend = w_x2;
            3'b100:         w_addend = -w_x2;
            3'b101, 3'b110: w_addend = -w_x1;
            default:        w_addend = '0;
        endcase
    end

    assign w_sum     = r_acc[AW-1:W] + w_addend;
    assign w_acc_nxt = {{2{w_sum[W]}}, w_sum, r_acc[W-1:2]};

    // Result is taken from the post-step accumulator so product and valid appear together.
    assign w_w32 = w_acc_nxt[WLSB+31:WLSB];
    always_comb begin
        case (r_op)
            OP_MUL:  w_result = w_acc_nxt[XLEN-1:0];
            OP_MULW: w_result = XLEN'($signed(w_w32));
            default: w_result = w_acc_nxt[2*XLEN-1:XLEN];
        endcase
    end

    assign w_unused_acc = ^w_acc_nxt[AW-1:2*XLEN];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_zero ? S_DONE : S_CALC;
            S_CALC:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_riscv_mul_kill) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_riscv_mul_clk or posedge i_riscv_mul_rst) begin
        if (i_riscv_mul_rst) r_state <= S_IDLE;
        else                 r_state <= w_state_nxt;
    end

    always_ff @(posedge i_riscv_mul_clk or posedge i_riscv_mul_rst) begin
        if (i_riscv_mul_rst) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_yprev   <= 1'b0;
            r_x       <= '0;
            r_op      <= OP_MUL;
            r_product <= '0;
        end else if (r_state == S_CALC && !i_riscv_mul_kill) begin
            r_acc   <= w_acc_nxt;
            r_yprev <= r_acc[1];
            if (w_last) r_product <= w_result;
            else        r_count   <= r_count + 1'b1;
        end else if (w_accept) begin
            r_x     <= w_x_ext;
            r_op    <= w_op;
            r_acc   <= {{(W+1){1'b0}}, w_y_ext};
            r_yprev <= 1'b0;
            r_count <= '0;
            if (w_zero) r_product <= '0;
        end
    end

    assign o_riscv_mul_product = r_product;
    assign o_riscv_mul_valid   = (r_state == S_DONE);
    assign o_riscv_mul_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_riscv_booth4_multiplier.sv
// Bench for riscv_booth4_multiplier: XLEN=64 and XLEN=32 instances share one stimulus stream.
// Expected results are queued at accept; per-instance monitors pop and compare on every valid.
module tb_riscv_booth4_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [63:0] rs1 = '0;
    logic [63:0] rs2 = '0;

    logic [63:0] p64;
    logic        v64, b64;
    logic [31:0] p32;
    logic        v32, b32;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic [63:0] prod;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q64[$];
    exp_t q32[$];
    logic [63:0] last64 = '0;
    logic [63:0] last32 = '0;

    riscv_booth4_multiplier #(.XLEN(64)) u_dut64 (
        .i_riscv_mul_clk     (clk),
        .i_riscv_mul_rst     (rst),
        .i_riscv_mul_start   (start),
        .i_riscv_mul_kill    (kill),
        .i_riscv_mul_op      (op),
        .i_riscv_mul_rs1data (rs1),
        .i_riscv_mul_rs2data (rs2),
        .o_riscv_mul_product (p64),
        .o_riscv_mul_valid   (v64),
        .o_riscv_mul_busy    (b64)
    );

    riscv_booth4_multiplier #(.XLEN(32)) u_dut32 (
        .i_riscv_mul_clk     (clk),
        .i_riscv_mul_rst     (rst),
        .i_riscv_mul_start   (start),
        .i_riscv_mul_kill    (kill),
        .i_riscv_mul_op      (op),
        .i_riscv_mul_rs1data (rs1[31:0]),
        .i_riscv_mul_rs2data (rs2[31:0]),
        .o_riscv_mul_product (p32),
        .o_riscv_mul_valid   (v32),
        .o_riscv_mul_busy    (b32)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [129:0] ext(input int xl, input logic [63:0] v, input bit sgn);
        if (xl == 32) return sgn ? {{98{v[31]}}, v[31:0]} : {98'b0, v[31:0]};
        return sgn ? {{66{v[63]}}, v} : {66'b0, v};
    endfunction

    // Reference: exact wide product, then the architectural result slice.
    function automatic logic [63:0] ref_mul(input int xl, input logic [2:0] o_in,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [129:0] sa, sb, p;
        logic [2:0] o;
        o = o_in;
        if (o > 3'd4 || (o == 3'd4 && xl == 32)) o = 3'd0;
        case (o)
            3'd2: begin sa = ext(xl, a, 1'b1); sb = ext(xl, b, 1'b0); end
            3'd3: begin sa = ext(xl, a, 1'b0); sb = ext(xl, b, 1'b0); end
            3'd4: begin sa = ext(32, a, 1'b1); sb = ext(32, b, 1'b1); end
            default: begin sa = ext(xl, a, 1'b1); sb = ext(xl, b, 1'b1); end
        endcase
        p = sa * sb;
        case (o)
            3'd0:    return (xl == 64) ? p[63:0] : {32'b0, p[31:0]};
            3'd4:    return {{32{p[31]}}, p[31:0]};
            default: return (xl == 64) ? p[127:64] : {32'b0, p[63:32]};
        endcase
    endfunction

    function automatic int lat64(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        if (o == 3'd4) return (a[31:0] == 0 || b[31:0] == 0) ? 0 : 17;
        return (a == 0 || b == 0) ? 0 : 33;
    endfunction

    function automatic int lat32(input logic [63:0] a, input logic [63:0] b);
        return (a[31:0] == 0 || b[31:0] == 0) ? 0 : 17;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && v64) begin
            if (q64.size() == 0) check("valid64_without_request", {63'b0, v64}, 64'd0);
            else begin
                e = q64.pop_front();
                check("product64", p64, e.prod);
                check("latency64", 64'(cyc - e.acc), 64'(e.lat));
                last64 = e.prod;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && v32) begin
            if (q32.size() == 0) check("valid32_without_request", {63'b0, v32}, 64'd0);
            else begin
                e = q32.pop_front();
                check("product32", {32'b0, p32}, e.prod);
                check("latency32", 64'(cyc - e.acc), 64'(e.lat));
                last32 = e.prod;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((b64 || v64 || b32 || v32) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", {63'b0, b64}, 64'd0);
    endtask

    task automatic start_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                            output int t);
        wait_idle();
        op = o; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        start = 1'b0;
    endtask

    task automatic issue(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp64);
        int t;
        exp_t e;
        start_op(o, a, b, t);
        e.prod = exp64;              e.acc = t; e.lat = lat64(o, a, b); q64.push_back(e);
        e.prod = ref_mul(32, o, a, b); e.acc = t; e.lat = lat32(a, b);    q32.push_back(e);
    endtask

    initial begin
        int t, cnt, n;
        logic [63:0] a, b;
        logic [2:0]  o;

        // Reset values
        #1 rst = 1'b1;
        #1;
        check("rst_product64", p64, 64'd0);
        check("rst_valid64", {63'b0, v64}, 64'd0);
        check("rst_busy64", {63'b0, b64}, 64'd0);
        check("rst_product32", {32'b0, p32}, 64'd0);
        check("rst_busy32", {63'b0, b32}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // MUL -3*7, with busy cycles counted up to the valid cycle
        start_op(3'd0, -64'sd3, 64'd7, t);
        begin
            exp_t e;
            e.prod = 64'hFFFF_FFFF_FFFF_FFEB; e.acc = t; e.lat = 33; q64.push_back(e);
            e.prod = 64'h0000_0000_FFFF_FFEB; e.acc = t; e.lat = 17; q32.push_back(e);
        end
        cnt = 0; n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (v64) break;
            if (b64) cnt++;
            n++;
        end
        check("busy_cycles64", 64'(cnt), 64'd33);

        // Directed vectors, hand-computed XLEN=64 results
        issue(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        issue(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(3'd4, 64'h8000_0000, 64'd2, 64'h0);
        issue(3'd4, 64'h4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000);
        issue(3'd4, 64'hDEAD_0000_0000_0003, 64'hBEEF_0000_0000_0005, 64'd15);
        issue(3'd4, 64'hFFFF_0000_0000_0000, 64'd5, 64'h0);
        issue(3'd1, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(3'd3, 64'h8000_0000_0000_0000, 64'd4, 64'd2);
        issue(3'd0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
        issue(3'd7, 64'd5, 64'd6, 64'd30);
        issue(3'd0, 64'd0, 64'h1234, 64'd0);

        // Start pulsed while busy must be dropped: exactly one valid follows
        issue(3'd0, 64'h1_2345_6789, 64'h10, 64'h12_3456_7890);
        repeat (4) @(negedge clk);
        op = 3'd0; rs1 = 64'd5; rs2 = 64'd7; start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;

        // Kill mid-CALC: no valid, busy drops next cycle, product untouched
        start_op(3'd0, 64'h1111, 64'h2222, t);
        repeat (10) @(negedge clk);
        check("busy_before_kill", {63'b0, b64}, 64'd1);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_busy64", {63'b0, b64}, 64'd0);
        check("kill_busy32", {63'b0, b32}, 64'd0);
        check("kill_product64", p64, last64);
        check("kill_product32", {32'b0, p32}, last32);
        issue(3'd0, 64'd9, 64'd11, 64'd99);

        // Kill together with start in IDLE: kill wins
        wait_idle();
        kill = 1'b1; start = 1'b1; op = 3'd0; rs1 = 64'd3; rs2 = 64'd3;
        @(posedge clk);
        #1;
        kill = 1'b0; start = 1'b0;
        check("kill_start_busy64", {63'b0, b64}, 64'd0);

        // Asynchronous reset in the middle of CALC
        start_op(3'd1, 64'hABCD_EF01, 64'h1234, t);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_product64", p64, 64'd0);
        check("arst_busy64", {63'b0, b64}, 64'd0);
        check("arst_valid64", {63'b0, v64}, 64'd0);
        check("arst_product32", {32'b0, p32}, 64'd0);
        check("arst_busy32", {63'b0, b32}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        last64 = '0; last32 = '0;

        // Randomised operands against the reference model
        for (int i = 0; i < 120; i++) begin
            o = 3'($urandom_range(0, 7));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 17 == 3) a = '0;
            if (i % 23 == 5) b[31:0] = '0;
            issue(o, a, b, ref_mul(64, o, a, b));
        end

        // Drain
        n = 0;
        while ((q64.size() != 0 || q32.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain64", 64'(q64.size()), 64'd0);
        check("drain32", 64'(q32.size()), 64'd0);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
